// File: rtl/limn2600_timer.sv
// limn2600_timer: memory-mapped interval timer and interrupt source on the Limn2600 bus.
// Define LIMN2600_TIMER_PRESCALE_EN to add the 16-bit PRESCALE register at offset 0x10.
module limn2600_timer #(
  parameter logic [31:0] BASE  = 32'hF000_0000,
  parameter int          WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq
);

  // state | meaning
  // IDLE  | waiting for a cs cycle that hits the window
  // ACK   | rdy high for one cycle, data_out carries the latched read value
  // HOLD  | cs still held after ACK; wait for release before accepting again
  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
  state_t state, state_nxt;

  logic             ctrl_en, ctrl_ie, ctrl_auto;
  logic [WIDTH-1:0] reload, count;
  logic             pending;
  logic [31:0]      rd_data, rd_mux;
  logic             hit, access;
  logic             wr_ctrl, wr_reload, wr_count, wr_status;
  logic             tick, cnt_step, expire;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign hit       = cs && (addr[31:5] == BASE[31:5]);
  assign access    = (state == IDLE) && hit;
  assign wr_ctrl   = access && we && (addr[4:2] == 3'd0);
  assign wr_reload = access && we && (addr[4:2] == 3'd1);
  assign wr_count  = access && we && (addr[4:2] == 3'd2);
  assign wr_status = access && we && (addr[4:2] == 3'd3);

`ifdef LIMN2600_TIMER_PRESCALE_EN
  logic [15:0] prescale, pcnt;
  logic        wr_prescale;

  assign wr_prescale = access && we && (addr[4:2] == 3'd4);
  assign tick        = (pcnt == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_prescale)
        prescale <= data_in[15:0];
      if (wr_prescale || wr_ctrl)
        pcnt <= '0;
      else if (ctrl_en)
        pcnt <= tick ? 16'd0 : pcnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // A CTRL or COUNT write owns the edge: no decrement and no expiry alongside it.
  assign cnt_step = ctrl_en && tick && !wr_ctrl && !wr_count;
  assign expire   = cnt_step && (count <= WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_auto <= 1'b0;
      reload    <= '0;
      count     <= '0;
      pending   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= data_in[0];
        ctrl_ie   <= data_in[1];
        ctrl_auto <= data_in[2];
      end else if (expire && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end

      if (wr_reload)
        reload <= data_in[WIDTH-1:0];

      if (wr_count)
        count <= data_in[WIDTH-1:0];
      else if (expire)
        count <= ctrl_auto ? reload : '0;
      else if (cnt_step)
        count <= count - WIDTH'(1);

      // Expiry beats a simultaneous clear so no interrupt is lost.
      if (expire)
        pending <= 1'b1;
      else if (wr_status && data_in[0])
        pending <= 1'b0;
    end
  end

  assign irq = pending && ctrl_ie;

  always_comb begin
    rd_mux = '0;
    case (addr[4:2])
      3'd0:    rd_mux = {29'd0, ctrl_auto, ctrl_ie, ctrl_en};
      3'd1:    rd_mux = 32'(reload);
      3'd2:    rd_mux = 32'(count);
      3'd3:    rd_mux = {31'd0, pending};
`ifdef LIMN2600_TIMER_PRESCALE_EN
      3'd4:    rd_mux = {16'd0, prescale};
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_data <= '0;
    else if (access)
      rd_data <= we ? 32'd0 : rd_mux;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ACK;
      ACK:     state_nxt = cs ? HOLD : IDLE;
      HOLD:    if (!cs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy      = 1'b0;
    data_out = '0;
    if (state == ACK) begin
      rdy      = 1'b1;
      data_out = rd_data;
    end
  end

endmodule

// File: doc/limn2600_timer.md
Name: limn2600_timer

Overview:
- Memory-mapped interval timer and interrupt source on the Limn2600 system bus, alongside limn2600_SRAM.
- Decodes CPU bus cycles in its own address window and returns data with a rdy handshake.
- Drives the CPU `irq` input when a programmed countdown expires.
- Board ORs its `rdy`/`data_out` with the SRAM's; both outputs are 0 when not selected.

Parameters:
- BASE, 32'hF000_0000, window base; window is 32 bytes (addr[31:5] == BASE[31:5]).
- WIDTH, 32, counter/reload width (≤32); narrower values zero-extend on read.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cs  input  1  bus cycle request from CPU.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address; addr[4:2] selects register.
- data_in  input  32  write data from CPU.
- data_out  output  32  read data; 0 when not acknowledging.
- rdy  output  1  one-cycle acknowledge.
- irq  output  1  interrupt request, level.

Behaviour:
- Reset (rst low, async): CTRL=0, RELOAD=0, COUNT=0, PENDING=0, FSM=IDLE, rdy=0, data_out=0, irq=0.
- Register map (offset):
  - 0x00 CTRL: [0] EN, [1] IE, [2] AUTO; other bits read 0.
  - 0x04 RELOAD: read/write.
  - 0x08 COUNT: read current value; write loads it.
  - 0x0C STATUS: [0] PENDING; writing 1 clears it, writing 0 has no effect.
  - 0x10–0x1C: read 0, writes ignored, still acknowledged.
- Bus FSM states: IDLE, ACK, HOLD.
  - IDLE: on posedge with cs=1 and address hit, perform the write (if we) or latch the read data, then go to ACK. A miss stays in IDLE with no response.
  - ACK: rdy=1 and data_out=latched read value (0 for writes) for exactly one cycle. Next state is HOLD if cs=1, else IDLE.
  - HOLD: rdy=0; stay while cs=1; go to IDLE when cs=0. Prevents double access from a held cs.
  - Latency: rdy asserted on the cycle after cs is first sampled, i.e. 1 wait state.
  - Read data reflects register values at the sampling edge.
- Counter, evaluated every posedge when EN=1 and tick=1 (tick is 1 every cycle unless the optional feature is present):
  - COUNT > 1: COUNT ← COUNT−1.
  - COUNT ∈ {0,1}, expiry: PENDING ← 1. If AUTO, COUNT ← RELOAD; else COUNT ← 0 and EN ← 0.
  - With AUTO=1 and RELOAD=0 or 1, the timer expires every tick.
- Simultaneous events:
  - A bus write to CTRL or COUNT in the same edge as a counter update: the write wins and the counter update is suppressed for that edge (no decrement, no expiry).
  - A STATUS clear-write in the same edge as an expiry: PENDING stays 1 (set wins).
- irq = PENDING & IE, from registers, no combinational path from bus inputs. Clearing IE masks irq but leaves PENDING untouched.
- Reset mid-transaction: FSM returns to IDLE immediately and rdy drops. The CPU must reissue the cycle.

Optional Feature:
- Macro: LIMN2600_TIMER_PRESCALE_EN.
- Defined:
  - Adds a 16-bit PRESCALE register at offset 0x10 (read/write, reset 0) and an internal prescale counter PCNT.
  - tick=1 when PCNT==PRESCALE; PCNT then resets to 0, otherwise PCNT increments while EN=1.
  - Writing PRESCALE or CTRL clears PCNT. PRESCALE=0 gives a tick every cycle.
- Undefined: tick is always 1, and offset 0x10 reads 0 and ignores writes.

Test Plan:
- Reset/idle: hold rst low 3 cycles, release → rdy=0, irq=0, reads of 0x00/0x04/0x08/0x0C return 0. Access to BASE+0x20 gets no rdy.
- One-shot: write RELOAD ignored, COUNT=5, CTRL=0x3 → PENDING and irq=1 exactly 5 ticks after the CTRL write edge. Then COUNT=0, CTRL reads 0x2. Write STATUS=1 → irq=0.
- Auto-reload: RELOAD=3, COUNT=3, CTRL=0x7 → irq set every 3 cycles. Read COUNT sequence cycles 3,2,1. Clearing PENDING mid-run does not stop counting.
- Handshake: hold cs=1 for 6 cycles on a read of 0x04 → exactly one rdy pulse on cycle 2, none during HOLD. A second read after cs low gets a new rdy.
- Collision: clear-write to STATUS on the expiry edge → PENDING reads 1. COUNT write of 10 on an expiry edge → COUNT reads 10 and no expiry occurs.
- Prescale (macro on): PRESCALE=3, COUNT=2, CTRL=0x3 → irq after 8 cycles. With macro off, 0x10 reads 0 after a write of 0xFFFF.
